// File: rtl/vx_launch_pkg.sv
// Shared types and DCR address map for the kernel launch sequencer.
package vx_launch_pkg;

    localparam int VX_DCR_ADDR_WIDTH = 12;
    localparam int VX_DCR_DATA_WIDTH = 32;

    localparam logic [VX_DCR_ADDR_WIDTH-1:0] VX_DCR_BASE_STARTUP_ADDR0 = 12'h001;
    localparam logic [VX_DCR_ADDR_WIDTH-1:0] VX_DCR_BASE_STARTUP_ADDR1 = 12'h002;
    localparam logic [VX_DCR_ADDR_WIDTH-1:0] VX_DCR_BASE_STARTUP_ARG0  = 12'h003;
    localparam logic [VX_DCR_ADDR_WIDTH-1:0] VX_DCR_BASE_STARTUP_ARG1  = 12'h004;
    localparam logic [VX_DCR_ADDR_WIDTH-1:0] VX_DCR_BASE_MPM_CLASS     = 12'h005;

    localparam logic [2:0] CFG_LAST_IDX = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_DONE
    } launch_state_t;

endpackage

// File: rtl/vx_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear beats enable.
module vx_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vx_launch_ctrl.sv
// Host-side launch sequencer: writes the startup DCRs, then tracks the core
// through busy/idle and reports completion, elapsed cycles and failure flags.
module vx_launch_ctrl
    import vx_launch_pkg::*;
#(
    parameter int CYCLE_W   = 32,
    parameter int BUSY_WAIT = 16,
    parameter int TIMEOUT   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [63:0]                  startup_addr,
    input  logic [63:0]                  startup_arg,
    input  logic [VX_DCR_DATA_WIDTH-1:0] mpm_class,
    output logic                         dcr_write_valid,
    output logic [VX_DCR_ADDR_WIDTH-1:0] dcr_write_addr,
    output logic [VX_DCR_DATA_WIDTH-1:0] dcr_write_data,
    input  logic                         gpu_busy,
    output logic                         ctrl_busy,
    output logic                         done,
    output logic                         timed_out,
    output logic                         no_start,
    output logic [CYCLE_W-1:0]           run_cycles
);

    localparam int WAIT_W = $clog2(BUSY_WAIT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST    = WAIT_W'(BUSY_WAIT - 1);
    localparam logic [CYCLE_W-1:0] TIMEOUT_LAST = CYCLE_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    launch_state_t state, state_next;
    logic [2:0]                   cfg_idx, cfg_idx_next;
    logic [WAIT_W-1:0]            wait_cnt, wait_cnt_next;
    logic [63:0]                  addr_q, arg_q;
    logic [VX_DCR_DATA_WIDTH-1:0] mpm_q;
    logic                         timed_out_next, no_start_next;
    logic                         latch_cfg, cnt_clear, cnt_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cfg_idx   <= '0;
            wait_cnt  <= '0;
            addr_q    <= '0;
            arg_q     <= '0;
            mpm_q     <= '0;
            timed_out <= 1'b0;
            no_start  <= 1'b0;
        end else begin
            state     <= state_next;
            cfg_idx   <= cfg_idx_next;
            wait_cnt  <= wait_cnt_next;
            timed_out <= timed_out_next;
            no_start  <= no_start_next;
            if (latch_cfg) begin
                addr_q <= startup_addr;
                arg_q  <= startup_arg;
                mpm_q  <= mpm_class;
            end
        end
    end

    // Abort is applied after the case so it overrides every transition,
    // including a start arriving in the same cycle.
    always_comb begin
        state_next     = state;
        cfg_idx_next   = cfg_idx;
        wait_cnt_next  = wait_cnt;
        timed_out_next = timed_out;
        no_start_next  = no_start;
        latch_cfg      = 1'b0;
        cnt_clear      = 1'b0;
        cnt_en         = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next     = ST_CFG;
                    cfg_idx_next   = '0;
                    latch_cfg      = 1'b1;
                    cnt_clear      = 1'b1;
                    timed_out_next = 1'b0;
                    no_start_next  = 1'b0;
                end
            end
            ST_CFG: begin
                if (cfg_idx == CFG_LAST_IDX) begin
                    state_next    = ST_WAIT_BUSY;
                    wait_cnt_next = '0;
                end else begin
                    cfg_idx_next = cfg_idx + 3'd1;
                end
            end
            ST_WAIT_BUSY: begin
                if (gpu_busy) begin
                    state_next = ST_RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next    = ST_DONE;
                    no_start_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + WAIT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                if (!gpu_busy) begin
                    state_next = ST_DONE;
                end else if ((TIMEOUT != 0) && (run_cycles == TIMEOUT_LAST)) begin
                    state_next     = ST_DONE;
                    timed_out_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_next     = ST_IDLE;
            latch_cfg      = 1'b0;
            cnt_clear      = 1'b1;
            timed_out_next = 1'b0;
            no_start_next  = 1'b0;
        end
    end

    // Outputs decode only registered state, so reset clears them immediately.
    always_comb begin
        dcr_write_valid = 1'b0;
        dcr_write_addr  = '0;
        dcr_write_data  = '0;
        if (state == ST_CFG) begin
            dcr_write_valid = 1'b1;
            case (cfg_idx)
                3'd0: begin
                    dcr_write_addr = VX_DCR_BASE_STARTUP_ADDR0;
                    dcr_write_data = addr_q[31:0];
                end
                3'd1: begin
                    dcr_write_addr = VX_DCR_BASE_STARTUP_ADDR1;
                    dcr_write_data = addr_q[63:32];
                end
                3'd2: begin
                    dcr_write_addr = VX_DCR_BASE_STARTUP_ARG0;
                    dcr_write_data = arg_q[31:0];
                end
                3'd3: begin
                    dcr_write_addr = VX_DCR_BASE_STARTUP_ARG1;
                    dcr_write_data = arg_q[63:32];
                end
                default: begin
                    dcr_write_addr = VX_DCR_BASE_MPM_CLASS;
                    dcr_write_data = mpm_q;
                end
            endcase
        end
    end

    assign ctrl_busy = (state != ST_IDLE) && (state != ST_DONE);
    assign done      = (state == ST_DONE);

    vx_sat_counter #(
        .WIDTH (CYCLE_W)
    ) u_run_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (run_cycles)
    );

endmodule
